// File: rtl/mc_pkg.sv
// Shared types for the multicycle RV32I controller: FSM states, halt causes,
// decoded datapath control bundle and base-ISA opcode values.
package mc_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        HC_NONE            = 3'd0,
        HC_ILLEGAL         = 3'd1,
        HC_SYSTEM          = 3'd2,
        HC_MISALIGNED_PC   = 3'd3,
        HC_MISALIGNED_ADDR = 3'd4,
        HC_TIMEOUT         = 3'd5
    } halt_cause_e;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_e;
    typedef enum logic [1:0] {SRC_A_RS1, SRC_A_PC, SRC_A_ZERO} src_a_e;
    typedef enum logic       {SRC_B_RS2, SRC_B_IMM} src_b_e;
    typedef enum logic       {EXEC_ALU, EXEC_LINK} exec_e;
    typedef enum logic       {REGD_EXEC, REGD_MEM} regd_e;

    typedef struct packed {
        imm_e        imm_sel;
        src_a_e      src_a_sel;
        src_b_e      src_b_sel;
        logic [3:0]  alu_func;    // {funct7_5, funct3}; funct7_5 only for OP and shift-right immediates
        logic        shift_op;
        exec_e       exec_sel;
        logic [2:0]  mem_size;
        regd_e       regd_sel;
        logic        branch_neg;
    } ctrl_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/mc_controller_wait_timer.sv
// Memory wait counter: counts cycles a request has waited without ready.
// Latency: expired is combinational from the registered count.
// Backpressure: none; holds at the limit, MAX_WAIT=0 never expires.
module wait_timer #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    input  logic ready,
    output logic expired
);
    localparam bit          ENABLED = (MAX_WAIT > 0);
    localparam int unsigned W       = ENABLED ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [W-1:0] LIMIT  = W'(MAX_WAIT);

    logic [W-1:0] count_q;
    logic         at_limit;

    assign at_limit = (count_q == LIMIT);
    assign expired  = ENABLED && count_en && !ready && at_limit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count_q <= '0;
        else if (clear)
            count_q <= '0;
        else if (count_en && !ready && !at_limit)
            count_q <= count_q + W'(1);
    end
endmodule

// File: rtl/mc_controller.sv
// Multicycle RV32I control FSM with combinational decode and halt/unhalt handling.
// Latency: one state per cycle; FETCH and MEM stretch until imem_ready/dmem_ready.
// Backpressure: requests held until ready or until the wait timer halts the core.
module mc_controller
    import mc_pkg::*;
#(
    parameter int unsigned MAX_WAIT     = 15,
    parameter int unsigned CNT_W        = 32,
    parameter bit          RESET_HALTED = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    output logic             imem_req,
    input  logic             imem_ready,
    output logic             ir_write,
    output logic             dmem_req,
    input  logic             dmem_ready,
    output logic             mem_write,
    output logic             reg_write,
    output logic             pc_write,
    output logic             pc_sel,
    input  logic             branch_taken,
    input  logic             misaligned_pc,
    input  logic             misaligned_addr,
    output ctrl_t            ctrl,
    output logic             halted,
    input  logic             unhalt,
    output logic [2:0]       halt_cause,
    output logic             retire,
    output logic [CNT_W-1:0] instret
);
    state_e            state_q, state_nxt;
    halt_cause_e       cause_q, cause_nxt;
    logic [CNT_W-1:0]  instret_q;
    logic              first_q;
    logic              wait_expired, wait_clear, wait_en, wait_ready;
    logic              is_load, is_store, is_branch, is_jump, is_system, known, take, retire_slot;

    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_jump   = (opcode == OPC_JAL) || (opcode == OPC_JALR);
    assign is_system = (opcode == OPC_SYSTEM);
    assign known     = is_load || is_store || is_branch || is_jump || is_system ||
                       (opcode == OPC_OP) || (opcode == OPC_OP_IMM) ||
                       (opcode == OPC_LUI) || (opcode == OPC_AUIPC);
    assign take      = is_jump || (is_branch && (branch_taken ^ ctrl.branch_neg));

    always_comb begin
        ctrl            = '0;
        ctrl.mem_size   = funct3;
        ctrl.branch_neg = is_branch && funct3[0];
        case (opcode)
            OPC_LUI:    begin ctrl.imm_sel = IMM_U; ctrl.src_a_sel = SRC_A_ZERO; ctrl.src_b_sel = SRC_B_IMM; end
            OPC_AUIPC:  begin ctrl.imm_sel = IMM_U; ctrl.src_a_sel = SRC_A_PC;   ctrl.src_b_sel = SRC_B_IMM; end
            OPC_JAL:    begin ctrl.imm_sel = IMM_J; ctrl.src_a_sel = SRC_A_PC;   ctrl.src_b_sel = SRC_B_IMM;
                              ctrl.exec_sel = EXEC_LINK; end
            OPC_JALR:   begin ctrl.imm_sel = IMM_I; ctrl.src_b_sel = SRC_B_IMM;  ctrl.exec_sel = EXEC_LINK; end
            OPC_BRANCH: ctrl.imm_sel = IMM_B;
            OPC_LOAD:   begin ctrl.imm_sel = IMM_I; ctrl.src_b_sel = SRC_B_IMM;  ctrl.regd_sel = REGD_MEM; end
            OPC_STORE:  begin ctrl.imm_sel = IMM_S; ctrl.src_b_sel = SRC_B_IMM; end
            OPC_OP_IMM: begin
                ctrl.imm_sel   = IMM_I;
                ctrl.src_b_sel = SRC_B_IMM;
                // funct7_5 of an immediate only selects arithmetic vs logical shift right
                ctrl.alu_func  = {funct7_5 && (funct3 == 3'b101), funct3};
                ctrl.shift_op  = (funct3[1:0] == 2'b01);
            end
            OPC_OP: begin
                ctrl.alu_func = {funct7_5, funct3};
                ctrl.shift_op = (funct3[1:0] == 2'b01);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt   = state_q;
        cause_nxt   = cause_q;
        imem_req    = 1'b0;
        ir_write    = 1'b0;
        dmem_req    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        pc_write    = 1'b0;
        pc_sel      = 1'b0;
        retire      = 1'b0;
        retire_slot = 1'b0;
        case (state_q)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write  = 1'b1;
                    state_nxt = DECODE;
                end else if (wait_expired) begin
                    state_nxt = HALT;
                    cause_nxt = HC_TIMEOUT;
                end
            end
            DECODE: begin
                if (!known) begin
                    state_nxt = HALT;
                    cause_nxt = HC_ILLEGAL;
                end else if (is_system) begin
                    state_nxt = HALT;
                    cause_nxt = HC_SYSTEM;
                end else begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (is_load || is_store) state_nxt = MEM;
                else if (is_branch)      retire_slot = 1'b1;
                else                     state_nxt = WB;
            end
            MEM: begin
                if (first_q && misaligned_addr) begin
                    state_nxt = HALT;
                    cause_nxt = HC_MISALIGNED_ADDR;
                end else begin
                    dmem_req  = 1'b1;
                    mem_write = is_store;
                    if (dmem_ready) begin
                        if (is_load) state_nxt = WB;
                        else         retire_slot = 1'b1;
                    end else if (wait_expired) begin
                        state_nxt = HALT;
                        cause_nxt = HC_TIMEOUT;
                    end
                end
            end
            WB: begin
                reg_write   = 1'b1;
                retire_slot = 1'b1;
            end
            HALT: begin
                if (unhalt) begin
                    state_nxt = FETCH;
                    cause_nxt = HC_NONE;
                end
            end
            default: state_nxt = FETCH;
        endcase

        // A taken jump/branch to a misaligned target aborts the retire entirely
        if (retire_slot) begin
            pc_sel = take;
            if (misaligned_pc && take) begin
                reg_write = 1'b0;
                state_nxt = HALT;
                cause_nxt = HC_MISALIGNED_PC;
            end else begin
                pc_write  = 1'b1;
                retire    = 1'b1;
                state_nxt = FETCH;
            end
        end

        // Requests vanish the instant reset rises, not at the next edge
        if (reset) begin
            imem_req  = 1'b0;
            ir_write  = 1'b0;
            dmem_req  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            pc_write  = 1'b0;
            pc_sel    = 1'b0;
            retire    = 1'b0;
        end
    end

    assign wait_en    = (state_q == FETCH) || (state_q == MEM);
    assign wait_ready = (state_q == FETCH) ? imem_ready : dmem_ready;
    assign wait_clear = (state_nxt != state_q) && ((state_nxt == FETCH) || (state_nxt == MEM));

    wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (wait_clear),
        .count_en (wait_en),
        .ready    (wait_ready),
        .expired  (wait_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RESET_HALTED ? HALT : FETCH;
            cause_q   <= HC_NONE;
            instret_q <= '0;
            first_q   <= 1'b1;
        end else begin
            state_q   <= state_nxt;
            cause_q   <= cause_nxt;
            first_q   <= (state_nxt != state_q);
            if (retire)
                instret_q <= instret_q + CNT_W'(1);
        end
    end

    assign halted     = (state_q == HALT);
    assign halt_cause = cause_q;
    assign instret    = instret_q;
endmodule
